// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with sub-word load extraction and a
// read-modify-write sequence for byte/half stores.
module dmem_arbiter #(
  parameter int RR_EN = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [1:0]  p0_size,
  input  logic        p0_unsigned,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [1:0]  p1_size,
  input  logic        p1_unsigned,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,
  output logic        mem_write,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_RMW_WR = 1'b1} state_t;

  localparam logic RR_ON = (RR_EN != 0);

  function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lo);
    logic bad;
    case (size)
      2'b00:   bad = 1'b0;
      2'b01:   bad = lo[0];
      2'b10:   bad = (lo != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_extract(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lo, input logic uns);
    logic [31:0] res;
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{lo, 3'b000} +: 8];
    h = lo[1] ? word[31:16] : word[15:0];
    case (size)
      2'b00:   res = uns ? {24'h000000, b} : {{24{b[7]}}, b};
      2'b01:   res = uns ? {16'h0000, h} : {{16{h[15]}}, h};
      2'b10:   res = word;
      default: res = 32'h00000000;
    endcase
    return res;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] word, input logic [31:0] wdata,
                                              input logic [1:0] size, input logic [1:0] lo);
    logic [31:0] res;
    res = word;
    case (size)
      2'b00: res[{lo, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lo[1]) res[31:16] = wdata[15:0];
        else       res[15:0]  = wdata[15:0];
      end
      default: res = wdata;
    endcase
    return res;
  endfunction

  state_t      state_q, state_d;
  logic        last_grant_q, last_grant_d;
  logic [1:0]  rvalid_q, rvalid_d;
  logic [1:0]  err_q, err_d;
  logic [31:0] rdata0_q, rdata0_d;
  logic [31:0] rdata1_q, rdata1_d;
  logic [31:0] rmw_addr_q, rmw_addr_d;
  logic [31:0] rmw_data_q, rmw_data_d;

  logic        sel1_s, grant_s, illegal_s, legal_s;
  logic        sel_we_s, sel_uns_s;
  logic [1:0]  sel_size_s;
  logic [31:0] sel_addr_s, sel_wdata_s, word_addr_s;
  logic        rd_s, wr_word_s, part_st_s;
  logic [31:0] ld_result_s, merged_s;

  // Arbitration and decode of the winning request.
  always_comb begin
    if (p0_req && p1_req) sel1_s = RR_ON ? (last_grant_q == 1'b0) : 1'b0;
    else                  sel1_s = p1_req;
    grant_s     = (state_q == ST_IDLE) && (p0_req || p1_req);
    sel_we_s    = sel1_s ? p1_we       : p0_we;
    sel_uns_s   = sel1_s ? p1_unsigned : p0_unsigned;
    sel_size_s  = sel1_s ? p1_size     : p0_size;
    sel_addr_s  = sel1_s ? p1_addr     : p0_addr;
    sel_wdata_s = sel1_s ? p1_wdata    : p0_wdata;
    word_addr_s = {sel_addr_s[31:2], 2'b00};
    illegal_s   = is_illegal(sel_size_s, sel_addr_s[1:0]);
    legal_s     = grant_s && !illegal_s;
    wr_word_s   = legal_s && sel_we_s && (sel_size_s == 2'b10);
    part_st_s   = legal_s && sel_we_s && (sel_size_s != 2'b10);
    rd_s        = legal_s && !wr_word_s;
    ld_result_s = illegal_s ? 32'h00000000
                            : load_extract(mem_rdata, sel_size_s, sel_addr_s[1:0], sel_uns_s);
    merged_s    = store_merge(mem_rdata, sel_wdata_s, sel_size_s, sel_addr_s[1:0]);
  end

  // Next-state for FSM, response pulses and the captured RMW word.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rvalid_d     = 2'b00;
    err_d        = 2'b00;
    rdata0_d     = rdata0_q;
    rdata1_d     = rdata1_q;
    rmw_addr_d   = rmw_addr_q;
    rmw_data_d   = rmw_data_q;
    case (state_q)
      ST_IDLE: begin
        if (grant_s) begin
          last_grant_d = sel1_s;
          rvalid_d     = {sel1_s & ~sel_we_s, ~sel1_s & ~sel_we_s};
          err_d        = {sel1_s & illegal_s, ~sel1_s & illegal_s};
          if (!sel_we_s) begin
            if (sel1_s) rdata1_d = ld_result_s;
            else        rdata0_d = ld_result_s;
          end else begin
            rdata0_d = rdata0_q;
          end
          if (part_st_s) begin
            state_d    = ST_RMW_WR;
            rmw_addr_d = word_addr_s;
            rmw_data_d = merged_s;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RMW_WR: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State registers; reset abandons any pending RMW write.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      rvalid_q     <= 2'b00;
      err_q        <= 2'b00;
      rdata0_q     <= 32'h00000000;
      rdata1_q     <= 32'h00000000;
      rmw_addr_q   <= 32'h00000000;
      rmw_data_q   <= 32'h00000000;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rvalid_q     <= rvalid_d;
      err_q        <= err_d;
      rdata0_q     <= rdata0_d;
      rdata1_q     <= rdata1_d;
      rmw_addr_q   <= rmw_addr_d;
      rmw_data_q   <= rmw_data_d;
    end
  end

  assign busy      = (state_q == ST_RMW_WR);
  assign p0_gnt    = grant_s && !sel1_s;
  assign p1_gnt    = grant_s && sel1_s;
  assign p0_rvalid = rvalid_q[0];
  assign p1_rvalid = rvalid_q[1];
  assign p0_err    = err_q[0];
  assign p1_err    = err_q[1];
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign mem_read  = rd_s;
  assign mem_write = busy || wr_word_s;
  assign mem_addr  = busy ? rmw_addr_q : (legal_s ? word_addr_s : 32'h00000000);
  assign mem_wdata = busy ? rmw_data_q : (wr_word_s ? sel_wdata_s : 32'h00000000);

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter RR_EN, default 1, meaning: 1 = round-robin between ports, 0 = fixed priority to port 0.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 pN_* signals exist twice, for N = 0 (core load/store unit) and N = 1 (debug/DMA master), with identical behaviour.
REQ-005 pN_req  in  1  request valid; held until pN_gnt.
REQ-006 pN_we  in  1  1 = store, 0 = load.
REQ-007 pN_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
REQ-008 pN_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
REQ-009 pN_addr  in  32  byte address.
REQ-010 pN_wdata  in  32  store data, right-aligned.
REQ-011 pN_gnt  out  1  combinational one-cycle pulse: request accepted this cycle.
REQ-012 pN_rvalid  out  1  registered pulse one cycle after a load grant.
REQ-013 pN_rdata  out  32  extracted and extended load data, valid with pN_rvalid.
REQ-014 pN_err  out  1  registered pulse one cycle after grant of an illegal request.
REQ-015 mem_write  out  1  to data memory write enable (synchronous write).
REQ-016 mem_read  out  1  to data memory read indication.
REQ-017 mem_addr  out  32  to data memory byte address; bits [1:0] always 00.
REQ-018 mem_wdata  out  32  to data memory write word.
REQ-019 mem_rdata  in  32  from data memory, combinational read of mem_addr.
REQ-020 busy  out  1  high while in RMW_WR.

Function
- REQ-021 FSM states IDLE and RMW_WR; grants SHALL only be issued in IDLE.
- REQ-022 Arbitration in IDLE: one requester -> it wins; both with RR_EN=1 -> port != last_grant wins; RR_EN=0 -> port 0 wins; last_grant updates on every grant.
- REQ-023 Illegal: size 11, half with addr[0]=1, word with addr[1:0]!=00; SHALL grant, assert no mem_read/mem_write, pulse pN_err next cycle (plus pN_rvalid with rdata 0 if load).
- REQ-024 Load at cycle T: pN_gnt=1, mem_read=1, mem_addr={addr[31:2],00}; at T+1 pN_rvalid=1 with lane extracted (byte lane addr[1:0], half lane addr[1]) and extended per pN_unsigned.
- REQ-025 Word store at cycle T: pN_gnt=1, mem_write=1, mem_wdata=pN_wdata; stay IDLE.
- REQ-026 Byte/half store at T: pN_gnt=1, mem_read=1, capture merged word (mem_rdata with selected lane replaced by wdata[7:0] or wdata[15:0]) and word address; go RMW_WR.
- REQ-027 RMW_WR at T+1: mem_write=1, mem_addr/mem_wdata from captured values, busy=1, no grants; return to IDLE at T+2.
- REQ-028 A load to the same word granted at T+2 SHALL return the merged data.
- REQ-029 mem_read and mem_write SHALL never both be high; all mem_* outputs 0 when idle with no request.
- REQ-030 At most one pN_gnt, pN_rvalid and pN_err high per cycle across both ports.

Reset
- REQ-031 reset=0 SHALL immediately force state IDLE, last_grant=1, all gnt/rvalid/err/busy/mem_write/mem_read to 0, rdata registers to 0.
- REQ-032 Reset asserted in RMW_WR SHALL abort the pending write (no memory update).
- REQ-033 First grant after reset release with both requesting SHALL go to port 0.

Verification
- V1 p0 sw addr 0x10 data 0xDEADBEEF, then p0 lw 0x10 -> mem_write at grant cycle; rvalid next cycle, rdata 0xDEADBEEF.
- V2 memory[0x20]=0x11223344; p1 sb addr 0x22 data 0xAA -> gnt, then busy one cycle; lw 0x20 returns 0x11AA3344.
- V3 memory[0x30]=0x80F07F01; lb 0x32 -> 0xFFFFFFF0; lbu 0x32 -> 0x000000F0; lh 0x32 -> 0xFFFF80F0; lhu 0x30 -> 0x00007F01.
- V4 both ports request continuously, RR_EN=1 -> grants alternate p0,p1,p0,...; RR_EN=0 -> p0 every cycle, p1 starved.
- V5 p0 lw 0x13 and sh 0x31 -> gnt, err pulse next cycle, no mem_read/mem_write asserted.
- V6 p0 sh 0x40 then reset=0 in RMW_WR -> mem_write drops same cycle, memory[0x40] unchanged, outputs zeroed.
